// File: rtl/i2c_codec_responder.sv
// I2C write-only target for a codec control port: 7-bit register address + 9-bit data per byte pair.
// Optional 16x9 shadow register file enabled with `define I2C_REGFILE_EN.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic [7:0] o_frame_cnt,
  output logic       o_busy,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACK_A  = 3'd2,
    S_BYTE1  = 3'd3,
    S_ACK_1  = 3'd4,
    S_BYTE2  = 3'd5,
    S_ACK_2  = 3'd6,
    S_IGNORE = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  state_t                 r_state;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift, r_byte1, r_byte2;
  logic                   r_sda_oen, r_valid, r_frame_err, r_busy;
  logic [6:0]             r_reg_addr;
  logic [8:0]             r_reg_data;
  logic [7:0]             r_frame_cnt;

  // Synchronise the bus lines and keep one cycle of history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_mid_pair, w_wr_en;
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_wr_en    = (r_state == S_ACK_2) && w_scl_fall;
  // A STOP/START always costs one sampled bit at a pair boundary, so BYTE1 with <=1 bit is not mid-pair.
  assign w_mid_pair = (r_state == S_ACK_1) || (r_state == S_BYTE2) || (r_state == S_ACK_2) ||
                      ((r_state == S_BYTE1) && (r_bit_cnt > 4'd1));

  // Protocol FSM with registered ACK drive, write outputs and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_byte1     <= 8'd0;
      r_byte2     <= 8'd0;
      r_sda_oen   <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_addr  <= 7'd0;
      r_reg_data  <= 9'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start || w_stop) begin
        r_frame_err <= w_mid_pair;
        r_sda_oen   <= 1'b0;
        r_bit_cnt   <= 4'd0;
        r_busy      <= w_start;
        r_state     <= w_start ? S_ADDR : S_IDLE;
      end else begin
        case (r_state)
          S_ADDR, S_BYTE1, S_BYTE2: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if ((r_shift[7:1] == DEV_ADDR) && !r_shift[0]) begin
                  r_sda_oen <= 1'b1;
                  r_state   <= S_ACK_A;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else if (r_state == S_BYTE1) begin
                r_byte1   <= r_shift;
                r_sda_oen <= 1'b1;
                r_state   <= S_ACK_1;
              end else begin
                r_byte2   <= r_shift;
                r_sda_oen <= 1'b1;
                r_state   <= S_ACK_2;
              end
            end
          end
          S_ACK_A, S_ACK_1: begin
            if (w_scl_fall) begin
              r_sda_oen <= 1'b0;
              r_state   <= (r_state == S_ACK_A) ? S_BYTE1 : S_BYTE2;
            end
          end
          S_ACK_2: begin
            if (w_scl_fall) begin
              r_sda_oen  <= 1'b0;
              r_valid    <= 1'b1;
              r_reg_addr <= r_byte1[7:1];
              r_reg_data <= {r_byte1[0], r_byte2};
              if (r_frame_cnt != 8'hFF) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
              r_state <= S_BYTE1;
            end
          end
          S_IDLE, S_IGNORE: begin
            r_sda_oen <= 1'b0;
          end
          default: begin
            r_sda_oen <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_sda_oen   = r_sda_oen;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_data  = r_reg_data;
  assign o_frame_cnt = r_frame_cnt;

`ifdef I2C_REGFILE_EN
  logic [8:0] r_regfile [16];

  // Shadow register file; a write to register 0x0F is the codec reset and clears every entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) r_regfile[i] <= 9'd0;
    end else if (w_wr_en) begin
      if (r_byte1[7:1] == 7'h0F) begin
        for (int i = 0; i < 16; i++) r_regfile[i] <= 9'd0;
      end else begin
        r_regfile[r_byte1[4:1]] <= {r_byte1[0], r_byte2};
      end
    end
  end

  assign o_rd_data = r_regfile[i_rd_addr];
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{i_rd_addr, w_wr_en};
  assign o_rd_data   = 9'd0;
`endif

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: bit-banged I2C initiator with wired-AND SDA.
module tb_i2c_codec_responder;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl, tb_sda, bus_sda;
  logic       o_sda_oen, o_valid, o_frame_err, o_busy;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data, o_rd_data;
  logic [7:0] o_frame_cnt;
  logic [3:0] rd_addr;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int oen_cycles = 0;
  logic [6:0] cap_addr[$];
  logic [8:0] cap_data[$];

  always #5 clk = ~clk;
  assign bus_sda = tb_sda & ~o_sda_oen;

  i2c_codec_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl), .i_sda(bus_sda),
    .o_sda_oen(o_sda_oen), .o_reg_addr(o_reg_addr), .o_reg_data(o_reg_data),
    .o_valid(o_valid), .o_frame_err(o_frame_err), .o_frame_cnt(o_frame_cnt),
    .o_busy(o_busy), .i_rd_addr(rd_addr), .o_rd_data(o_rd_data)
  );

  always @(negedge clk) begin
    if (o_valid) begin
      cap_addr.push_back(o_reg_addr);
      cap_data.push_back(o_reg_data);
    end
    if (o_frame_err) err_pulses++;
    if (o_sda_oen) oen_cycles++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; wq(Q); scl = 1'b1; wq(Q); tb_sda = 1'b0; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; wq(Q); scl = 1'b1; wq(Q); tb_sda = 1'b1; wq(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tb_sda = b[i]; wq(Q); scl = 1'b1; wq(Q); scl = 1'b0; wq(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    tb_sda = 1'b1; wq(Q); scl = 1'b1; wq(Q / 2);
    ack = ~bus_sda;
    wq(Q / 2); scl = 1'b0; wq(Q);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scl = 1'b1; tb_sda = 1'b1; wq(4); rst_n = 1'b1; wq(4);
  endtask

  task automatic write_frame(input logic [7:0] b1, input logic [7:0] b2);
    logic a;
    i2c_start(); send_byte(8'h34, a); send_byte(b1, a); send_byte(b2, a); i2c_stop();
  endtask

  initial begin
    logic a0, a1, a2;
    int v0, e0, o0;
    rd_addr = 4'd7;
    rst_n = 1'b0; scl = 1'b1; tb_sda = 1'b1;
    wq(4);
    check_val("rst_oen", o_sda_oen, 1'b0);
    check_val("rst_valid", o_valid, 1'b0);
    check_val("rst_err", o_frame_err, 1'b0);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_addr", o_reg_addr, 7'd0);
    check_val("rst_data", o_reg_data, 9'd0);
    check_val("rst_cnt", o_frame_cnt, 8'd0);
    check_val("rst_rd", o_rd_data, 9'd0);
    rst_n = 1'b1; wq(4);

    // Address byte without a preceding START must be ignored.
    scl = 1'b0; wq(Q);
    send_byte(8'h34, a0);
    check_val("nostart_ack", a0, 1'b0);
    check_val("nostart_busy", o_busy, 1'b0);
    i2c_stop();

    // Single write to register 0x0F.
    do_reset();
    i2c_start();
    check_val("t1_busy", o_busy, 1'b1);
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    i2c_stop();
    check_val("t1_ack_a", a0, 1'b1);
    check_val("t1_ack_1", a1, 1'b1);
    check_val("t1_ack_2", a2, 1'b1);
    check_val("t1_nvalid", cap_addr.size(), 1);
    check_val("t1_addr", cap_addr[0], 7'h0F);
    check_val("t1_data", cap_data[0], 9'h000);
    check_val("t1_cnt", o_frame_cnt, 8'd1);
    check_val("t1_err", err_pulses, 0);
    check_val("t1_idle", o_busy, 1'b0);
    check_val("t1_oen_rel", o_sda_oen, 1'b0);

    // Auto-continue: two byte pairs in one frame.
    do_reset();
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h15, a2);
    send_byte(8'h0C, a1); send_byte(8'h00, a2);
    i2c_stop();
    check_val("t2_nvalid", cap_addr.size(), 3);
    check_val("t2_addr0", cap_addr[1], 7'h04);
    check_val("t2_data0", cap_data[1], 9'h015);
    check_val("t2_addr1", cap_addr[2], 7'h06);
    check_val("t2_data1", cap_data[2], 9'h000);
    check_val("t2_cnt", o_frame_cnt, 8'd2);
    check_val("t2_err", err_pulses, 0);

    // Wrong address: no ACK, no write, busy until STOP.
    o0 = oen_cycles;
    i2c_start();
    send_byte(8'h36, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    check_val("t3_busy", o_busy, 1'b1);
    i2c_stop();
    check_val("t3_acks", {a0, a1, a2}, 3'b000);
    check_val("t3_oen", oen_cycles - o0, 0);
    check_val("t3_nvalid", cap_addr.size(), 3);
    check_val("t3_cnt", o_frame_cnt, 8'd2);
    check_val("t3_idle", o_busy, 1'b0);
    check_val("t3_err", err_pulses, 0);

    // Aborted pair, then a normal frame.
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h0E, a1);
    i2c_stop();
    check_val("t4_err", err_pulses, 1);
    check_val("t4_nvalid", cap_addr.size(), 3);
    check_val("t4_addr_hold", o_reg_addr, 7'h06);
    write_frame(8'h0A, 8'h33);
    check_val("t4_nvalid2", cap_addr.size(), 4);
    check_val("t4_addr", cap_addr[3], 7'h05);
    check_val("t4_data", cap_data[3], 9'h033);
    check_val("t4_cnt", o_frame_cnt, 8'd3);
    check_val("t4_err2", err_pulses, 1);

    // Repeated START on a pair boundary is not an error.
    i2c_start(); send_byte(8'h34, a0);
    i2c_start(); send_byte(8'h34, a0); send_byte(8'h11, a1); send_byte(8'h80, a2);
    i2c_stop();
    check_val("t5_err", err_pulses, 1);
    check_val("t5_addr", o_reg_addr, 7'h08);
    check_val("t5_data", o_reg_data, 9'h180);

    // Register file.
    do_reset();
    write_frame(8'h0E, 8'h42);
    rd_addr = 4'd7; #1;
`ifdef I2C_REGFILE_EN
    check_val("rf_r7", o_rd_data, 9'h042);
    rd_addr = 4'd6; #1;
    check_val("rf_r6", o_rd_data, 9'h000);
    write_frame(8'h1E, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      check_val("rf_clr", o_rd_data, 9'h000);
    end
`else
    check_val("rf_absent", o_rd_data, 9'h000);
`endif

    // Reset during the address ACK releases SDA asynchronously.
    i2c_start();
    send_bits(8'h34);
    check_val("t6_ack_on", o_sda_oen, 1'b1);
    #2 rst_n = 1'b0; #1;
    check_val("t6_async_rel", o_sda_oen, 1'b0);
    wq(4); rst_n = 1'b1; scl = 1'b1; wq(Q); tb_sda = 1'b1; wq(Q);
    check_val("t6_busy", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
